// File: rtl/cache_pkg.sv
// Shared widths, address layout, line type and FSM state encoding
// for the direct-mapped read cache.
package cache_pkg;

    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned OFFSET_W   = 2;
    localparam int unsigned INDEX_W    = 8;
    localparam int unsigned TAG_W      = 5;
    localparam int unsigned LINE_WORDS = 1 << OFFSET_W;
    localparam int unsigned NUM_LINES  = 1 << INDEX_W;

    typedef logic [WORD_W-1:0]   word_t;
    typedef word_t               line_t [0:LINE_WORDS-1];
    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [INDEX_W-1:0]  index_t;
    typedef logic [OFFSET_W-1:0] offset_t;

    // Field order matches the word address: tag[14:10], index[9:2], offset[1:0]
    typedef struct packed {
        tag_t    tag;
        index_t  index;
        offset_t offset;
    } addr_t;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        FILL,
        RESPOND
    } state_t;

endpackage

// File: rtl/cache_if.sv
// CPU request/response and backing-memory signals of the cache controller.
interface cache_if;
    import cache_pkg::*;

    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_flush;
    logic              cpu_rsp_valid;
    logic [WORD_W-1:0] cpu_rdata;
    logic              cpu_rsp_hit;
    logic [ADDR_W-1:0] mem_addr;
    line_t             mem_data;

    modport master (
        output cpu_req_valid, cpu_addr, cpu_flush, mem_data,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rdata, cpu_rsp_hit, mem_addr
    );

    modport slave (
        input  cpu_req_valid, cpu_addr, cpu_flush, mem_data,
        output cpu_req_ready, cpu_rsp_valid, cpu_rdata, cpu_rsp_hit, mem_addr
    );

endinterface

// File: rtl/cache_store.sv
// Tag, valid and data storage: combinational read port, single line-write port
// and a bulk invalidate. Only the valid bits are reset.
module cache_store
    import cache_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  index_t rd_index,
    output logic   rd_valid,
    output tag_t   rd_tag,
    output line_t  rd_line,
    input  logic   wr_en,
    input  index_t wr_index,
    input  tag_t   wr_tag,
    input  line_t  wr_line
);

    logic [NUM_LINES-1:0] valid;
    tag_t                 tags [NUM_LINES];
    line_t                data [NUM_LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_line  = data[rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped read cache controller: IDLE/COMPARE/FILL/RESPOND FSM with a
// fixed-latency refill from a combinational block memory and saturating statistics.
module cache_controller
    import cache_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    cache_if.slave      bus,
    output logic [15:0] access_count,
    output logic [15:0] hit_count
);

    localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state, state_n;
    addr_t       req_q;
    logic [3:0]  lat_cnt;
    word_t       rdata_q;
    logic        rsp_valid_q;
    logic        rsp_hit_q;
    logic [15:0] acc_cnt;
    logic [15:0] hit_cnt;

    logic        accept;
    logic        flush_clr;
    logic        fill_done;
    logic        hit;
    logic        st_valid;
    tag_t        st_tag;
    line_t       st_line;

    cache_store u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush_clr),
        .rd_index (req_q.index),
        .rd_valid (st_valid),
        .rd_tag   (st_tag),
        .rd_line  (st_line),
        .wr_en    (fill_done),
        .wr_index (req_q.index),
        .wr_tag   (req_q.tag),
        .wr_line  (bus.mem_data)
    );

    assign hit = st_valid && (st_tag == req_q.tag);

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        flush_clr = 1'b0;
        fill_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_flush) begin
                    flush_clr = 1'b1;
                end else if (bus.cpu_req_valid) begin
                    accept  = 1'b1;
                    state_n = COMPARE;
                end
            end
            COMPARE: state_n = hit ? RESPOND : FILL;
            FILL: begin
                if (lat_cnt == '0) begin
                    fill_done = 1'b1;
                    state_n   = RESPOND;
                end
            end
            RESPOND: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_q       <= '0;
            lat_cnt     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                req_q <= addr_t'(bus.cpu_addr);
            end
            case (state)
                COMPARE: begin
                    if (hit) begin
                        rdata_q <= st_line[req_q.offset];
                    end else begin
                        lat_cnt <= LAT_INIT;
                    end
                end
                FILL: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        rdata_q <= bus.mem_data[req_q.offset];
                    end
                end
                default: ;
            endcase
            // Registered strobes are high exactly while the FSM sits in RESPOND
            rsp_valid_q <= (state_n == RESPOND);
            rsp_hit_q   <= (state == COMPARE) && hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
            hit_cnt <= '0;
        end else if (state == RESPOND) begin
            if (acc_cnt != '1) begin
                acc_cnt <= acc_cnt + 16'd1;
            end
            if (rsp_hit_q && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
        end
    end

    assign bus.cpu_req_ready = (state == IDLE) && !bus.cpu_flush;
    assign bus.cpu_rsp_valid = rsp_valid_q;
    assign bus.cpu_rsp_hit   = rsp_hit_q;
    assign bus.cpu_rdata     = rdata_q;
    assign bus.mem_addr      = {req_q.tag, req_q.index, 2'b00};
    assign access_count      = acc_cnt;
    assign hit_count         = hit_cnt;

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: a driver models the cache as tag/valid
// arrays and queues expected responses; a monitor checks every DUT response.
module tb_cache_controller;
    import cache_pkg::*;

    localparam int unsigned LAT = 4;

    typedef struct {
        logic [31:0] rdata;
        bit          hit;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] access_count;
    logic [15:0] hit_count;

    cache_if bus();

    cache_controller #(.MEM_LATENCY(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .access_count (access_count),
        .hit_count    (hit_count)
    );

    always #5 clk = ~clk;

    // Backing memory: word i holds value i
    always_comb begin
        for (int unsigned k = 0; k < LINE_WORDS; k++) begin
            bus.mem_data[k] = 32'(bus.mem_addr) + k;
        end
    end

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          busy_until = -1;
    bit          mvalid [NUM_LINES];
    logic [4:0]  mtag [NUM_LINES];
    exp_t        q [$];
    exp_t        me;
    logic [31:0] last_rdata = '0;
    logic [15:0] m_acc = '0;
    logic [15:0] m_hit = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every response strobe
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cpu_rsp_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 required no outstanding request");
                end else begin
                    me = q.pop_front();
                    chk("rdata", bus.cpu_rdata, me.rdata);
                    chk("rsp_hit", 32'(bus.cpu_rsp_hit), 32'(me.hit));
                    chk("latency", 32'(cyc - me.acc), 32'(me.lat));
                    chk("access_count", 32'(access_count), 32'(m_acc));
                    chk("hit_count", 32'(hit_count), 32'(m_hit));
                    last_rdata = me.rdata;
                    if (m_acc != 16'hFFFF) m_acc++;
                    if (me.hit && m_hit != 16'hFFFF) m_hit++;
                end
            end else begin
                chk("rdata_hold", bus.cpu_rdata, last_rdata);
            end
        end
    end

    task automatic issue(input logic [14:0] a, input bit hold);
        bit         done = 0;
        int         idx;
        logic [4:0] tg;
        exp_t       e;
        bus.cpu_addr      = a;
        bus.cpu_req_valid = 1'b1;
        for (int unsigned i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            chk("req_ready", 32'(bus.cpu_req_ready), 32'(cyc > busy_until));
            if (bus.cpu_req_ready) begin
                done = 1;
                idx  = int'(a[9:2]);
                tg   = a[14:10];
                e.hit = mvalid[idx] && (mtag[idx] == tg);
                if (!e.hit) begin
                    mvalid[idx] = 1'b1;
                    mtag[idx]   = tg;
                end
                e.rdata = 32'(a);
                e.lat   = e.hit ? 2 : 2 + int'(LAT);
                e.acc   = cyc;
                q.push_back(e);
                busy_until = cyc + e.lat;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no acceptance required acceptance of %h", a);
        end
        @(posedge clk);
        #1;
        if (!hold) bus.cpu_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bus.cpu_req_valid = 1'b0;
        for (int unsigned i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cyc > busy_until) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input bit with_req, input logic [14:0] a);
        wait_idle();
        bus.cpu_flush     = 1'b1;
        bus.cpu_req_valid = with_req;
        bus.cpu_addr      = a;
        @(negedge clk);
        chk("flush_ready", 32'(bus.cpu_req_ready), 32'd0);
        foreach (mvalid[i]) mvalid[i] = 1'b0;
        @(posedge clk);
        #1;
        bus.cpu_flush     = 1'b0;
        bus.cpu_req_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_flush     = 1'b0;
        q.delete();
        foreach (mvalid[i]) mvalid[i] = 1'b0;
        m_acc = '0;
        m_hit = '0;
        last_rdata = '0;
        busy_until = -1;
        #1;
        chk("rst_rsp_valid", 32'(bus.cpu_rsp_valid), 32'd0);
        chk("rst_rsp_hit", 32'(bus.cpu_rsp_hit), 32'd0);
        chk("rst_rdata", bus.cpu_rdata, 32'd0);
        chk("rst_access", 32'(access_count), 32'd0);
        chk("rst_hits", 32'(hit_count), 32'd0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [14:0] ra;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_flush     = 1'b0;
        bus.cpu_addr      = '0;
        #2;
        apply_reset();

        // Cold miss then same-line hit, then a conflicting tag on index 1
        issue(15'h0005, 0);
        issue(15'h0006, 0);
        issue(15'h0405, 0);
        issue(15'h0005, 0);
        wait_idle();
        chk("conflict_access", 32'(access_count), 32'd4);
        chk("conflict_hits", 32'(hit_count), 32'd1);

        // Flush beats a simultaneous request
        do_flush(1, 15'h0006);
        issue(15'h0006, 0);

        // Reset in the second FILL cycle abandons the refill
        wait_idle();
        issue(15'h0010, 0);
        repeat (3) @(negedge clk);
        #1;
        apply_reset();
        issue(15'h0010, 0);

        // Randomised traffic over a small footprint, with flushes and held valid
        for (int unsigned n = 0; n < 80; n++) begin
            ra = {5'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0) begin
                do_flush(bit'($urandom_range(0, 1)), ra);
            end else begin
                issue(ra, bit'($urandom_range(0, 1)));
            end
        end

        // Explicit back-to-back burst with valid held high throughout
        wait_idle();
        for (int unsigned n = 0; n < 6; n++) begin
            issue(15'h0100 + 15'(n), 1);
        end

        // Hit counter saturation from a preloaded value
        wait_idle();
        issue(15'h0020, 0);
        wait_idle();
        force dut.hit_cnt = 16'hFFFE;
        m_hit = 16'hFFFE;
        #1;
        release dut.hit_cnt;
        issue(15'h0021, 0);
        issue(15'h0022, 0);
        issue(15'h0023, 0);
        wait_idle();
        chk("hit_saturate", 32'(hit_count), 32'h0000FFFF);

        for (int unsigned i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d outstanding required 0", q.size());
        end
        wait_idle();
        chk("final_access", 32'(access_count), 32'(m_acc));
        chk("final_hits", 32'(hit_count), 32'(m_hit));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, meaning the number of FILL cycles a line refill waits (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port cpu_req_valid, input, 1 bit, read request present.
REQ-005 SHALL have port cpu_req_ready, output, 1 bit, request accepted when valid&&ready.
REQ-006 SHALL have port cpu_addr, input, 15 bits, word address: tag[14:10], index[9:2], offset[1:0].
REQ-007 SHALL have port cpu_flush, input, 1 bit, pulse that invalidates all lines.
REQ-008 SHALL have port cpu_rsp_valid, output, 1 bit, one-cycle response strobe.
REQ-009 SHALL have port cpu_rdata, output, 32 bits, returned word.
REQ-010 SHALL have port cpu_rsp_hit, output, 1 bit, response was a hit; qualified by cpu_rsp_valid.
REQ-011 SHALL have port mem_addr, output, 15 bits, block address to dataMem, {req_tag, req_index, 2'b00}.
REQ-012 SHALL have port mem_data, input, 4x32 bits (unpacked [0:3]), combinational block read from dataMem.
REQ-013 SHALL have ports access_count and hit_count, outputs, 16 bits each, statistics counters.

Function
REQ-014 SHALL implement FSM states IDLE, COMPARE, FILL and RESPOND.
REQ-015 cpu_req_ready SHALL equal (state==IDLE) && !cpu_flush.
REQ-016 IDLE SHALL register cpu_addr on acceptance and go to COMPARE; without acceptance it stays in IDLE.
REQ-017 cpu_flush in IDLE SHALL clear all 256 valid bits in that cycle; flush wins over a simultaneous request; flush in any other state SHALL be ignored.
REQ-018 COMPARE SHALL declare a hit when valid[index] && tag[index]==req_tag; on a hit it registers word[offset] into cpu_rdata and goes to RESPOND.
REQ-019 On a miss, COMPARE SHALL load the latency counter with MEM_LATENCY-1 and go to FILL.
REQ-020 FILL SHALL decrement the counter each cycle; in the cycle the counter is 0 it writes mem_data[0..3] into the line, writes the tag, sets valid, registers mem_data[offset] into cpu_rdata and goes to RESPOND.
REQ-021 RESPOND SHALL assert cpu_rsp_valid for exactly one cycle, drive cpu_rsp_hit, and return to IDLE.
REQ-022 Hit latency SHALL be 2 cycles (acceptance edge to rsp_valid edge); miss latency SHALL be 2+MEM_LATENCY cycles.
REQ-023 cpu_rdata SHALL hold its value until the next response.
REQ-024 access_count SHALL increment in every RESPOND cycle and hit_count in every RESPOND cycle where hit=1; both saturate at 0xFFFF.
REQ-025 mem_addr SHALL be driven from the registered request in every state.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, all valid bits=0, cpu_rsp_valid=0, cpu_rsp_hit=0, cpu_rdata=0, both counters=0 and the latency counter=0.
REQ-027 Tag and data arrays SHALL NOT be reset.
REQ-028 Reset during FILL SHALL abandon the refill; the line stays invalid.

Structure
REQ-029 Package cache_pkg SHALL hold ADDR_W=15, WORD_W=32, OFFSET_W=2, INDEX_W=8, TAG_W=5, the line type (4x32) and the state enum.
REQ-030 Tag, valid and data storage SHALL be one sub-module, cache_store, with a read port and a line-write port; the FSM and counters stay in cache_controller.

Verification (dataMem word i holds value i; MEM_LATENCY=4)
REQ-031 After reset, read 0x0005 -> miss, rsp 6 cycles after acceptance, cpu_rdata=0x5, hit=0; then read 0x0006 -> hit, 2 cycles, rdata=0x6, hit=1.
REQ-032 Conflict: read 0x0405 (index 1, tag 1) -> miss, rdata=0x405; re-read 0x0005 -> miss, rdata=0x5; access_count=4, hit_count=1.
REQ-033 Flush asserted with valid in IDLE -> ready=0 and no acceptance that cycle; next read 0x0006 -> miss.
REQ-034 Assert rst_n low during cycle 2 of FILL for 0x0010 -> outputs at reset values immediately; re-read 0x0010 -> miss, rdata=0x10.
REQ-035 Preload hit_count=0xFFFE via forced state, issue 3 hits -> hit_count=0xFFFF and holds.
REQ-036 Back-to-back valid held high -> ready is low outside IDLE, and exactly one response per accepted request.
